// File: rtl/reg_file_sb_pkg.sv
// Shared widths and sizing helper for the register file with write-pending scoreboard.
package reg_file_sb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_PEND_W = 2;

    function automatic int unsigned num_regs(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read/write/issue/debug bus of the register file; slave is the register file, master is the core.
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] ADDR_1;
    logic [ADDR_W-1:0] ADDR_2;
    logic [DATA_W-1:0] DATA_1;
    logic [DATA_W-1:0] DATA_2;
    logic              BUSY_1;
    logic              BUSY_2;
    logic              WRITE_EN;
    logic [ADDR_W-1:0] WRITE_ADDR;
    logic [DATA_W-1:0] WRITE_DATA;
    logic              ISSUE_EN;
    logic [ADDR_W-1:0] ISSUE_ADDR;
    logic              ISSUE_STALL;
    logic              FLUSH;
    logic [ADDR_W-1:0] DBG_ADDR;
    logic [DATA_W-1:0] DBG_DATA;
    logic              ERR_UNDER;

    modport master (
        output ADDR_1, ADDR_2, WRITE_EN, WRITE_ADDR, WRITE_DATA,
               ISSUE_EN, ISSUE_ADDR, FLUSH, DBG_ADDR,
        input  DATA_1, DATA_2, BUSY_1, BUSY_2, ISSUE_STALL, DBG_DATA, ERR_UNDER
    );

    modport slave (
        input  ADDR_1, ADDR_2, WRITE_EN, WRITE_ADDR, WRITE_DATA,
               ISSUE_EN, ISSUE_ADDR, FLUSH, DBG_ADDR,
        output DATA_1, DATA_2, BUSY_1, BUSY_2, ISSUE_STALL, DBG_DATA, ERR_UNDER
    );

endinterface

// File: rtl/reg_file_sb_pend_counter.sv
// Per-register outstanding-write counter: flush clear (with optional reload to 1), up/down, saturation flag.
module pend_counter
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned PEND_W = DEF_PEND_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              clr,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              sat,
    output logic              under
);

    assign sat   = &cnt;
    // Only a lone write-back against an empty counter is an underflow.
    assign under = dec && !inc && !clr && (cnt == '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? PEND_W'(1) : '0;
        end else if (inc && !dec) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two bypassed read ports, one write port, debug read port and
// a per-register pending-write scoreboard for RAW stall detection.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned PEND_W   = DEF_PEND_W
) (
    input logic          CLK,
    input logic          RESET_N,
    reg_file_sb_if.slave bus
);

    localparam int unsigned NUM_REGS = num_regs(ADDR_W);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [PEND_W-1:0]   cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] sat;
    logic [NUM_REGS-1:0] under;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    logic              wr_ok;
    logic              stall;
    logic              err_q;
    logic              hit_1, hit_2, zero_1, zero_2;
    logic [DATA_W-1:0] data_1, data_2;
    logic              busy_1, busy_2;

    assign wr_ok = bus.WRITE_EN && !((ZERO_REG != 0) && (bus.WRITE_ADDR == '0));
    assign stall = bus.ISSUE_EN && sat[bus.ISSUE_ADDR] && !bus.FLUSH;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.WRITE_ADDR] <= bus.WRITE_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_q <= 1'b0;
        end else if (|under) begin
            err_q <= 1'b1;
        end
    end

    // A stalled issue leaves its counter alone, so a same-cycle write-back still decrements it.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        localparam bit COUNTED = (ZERO_REG == 0) || (r != 0);

        assign inc[r] = COUNTED && bus.ISSUE_EN && !stall && (bus.ISSUE_ADDR == ADDR_W'(r));
        assign dec[r] = COUNTED && wr_ok && (bus.WRITE_ADDR == ADDR_W'(r));

        pend_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .clr     (bus.FLUSH),
            .inc     (inc[r]),
            .dec     (dec[r]),
            .cnt     (cnt[r]),
            .sat     (sat[r]),
            .under   (under[r])
        );
    end

    always_comb begin
        zero_1 = (ZERO_REG != 0) && (bus.ADDR_1 == '0);
        zero_2 = (ZERO_REG != 0) && (bus.ADDR_2 == '0);
        hit_1  = (BYPASS != 0) && bus.WRITE_EN && (bus.WRITE_ADDR == bus.ADDR_1);
        hit_2  = (BYPASS != 0) && bus.WRITE_EN && (bus.WRITE_ADDR == bus.ADDR_2);

        if (zero_1)     data_1 = '0;
        else if (hit_1) data_1 = bus.WRITE_DATA;
        else            data_1 = regs[bus.ADDR_1];

        if (zero_2)     data_2 = '0;
        else if (hit_2) data_2 = bus.WRITE_DATA;
        else            data_2 = regs[bus.ADDR_2];

        // The last outstanding write landing this cycle is already visible through the bypass.
        busy_1 = !zero_1 && (cnt[bus.ADDR_1] != '0)
                 && !(hit_1 && (cnt[bus.ADDR_1] == PEND_W'(1)));
        busy_2 = !zero_2 && (cnt[bus.ADDR_2] != '0)
                 && !(hit_2 && (cnt[bus.ADDR_2] == PEND_W'(1)));
    end

    assign bus.DATA_1      = data_1;
    assign bus.DATA_2      = data_2;
    assign bus.BUSY_1      = busy_1;
    assign bus.BUSY_2      = busy_2;
    assign bus.ISSUE_STALL = stall;
    assign bus.DBG_DATA    = regs[bus.DBG_ADDR];
    assign bus.ERR_UNDER   = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb with hand-computed expectations.
module tb_reg_file_sb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_sb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1),
        .BYPASS   (1),
        .PEND_W   (2)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WRITE_EN   = 1'b0;
        bus.WRITE_ADDR = '0;
        bus.WRITE_DATA = '0;
        bus.ISSUE_EN   = 1'b0;
        bus.ISSUE_ADDR = '0;
        bus.FLUSH      = 1'b0;
    endtask

    initial begin
        idle();
        bus.ADDR_1   = '0;
        bus.ADDR_2   = '0;
        bus.DBG_ADDR = '0;
        #3;

        // 1. reset state
        for (int a = 0; a < 32; a++) begin
            bus.ADDR_1   = 5'(a);
            bus.ADDR_2   = 5'(31 - a);
            bus.DBG_ADDR = 5'(a);
            #0.1;
            check("rst_dbg", bus.DBG_DATA, 32'h0);
            check("rst_d1", bus.DATA_1, 32'h0);
            check("rst_d2", bus.DATA_2, 32'h0);
        end
        check("rst_busy", {30'b0, bus.BUSY_1, bus.BUSY_2}, 32'h0);
        check("rst_err", {31'b0, bus.ERR_UNDER}, 32'h0);
        check("rst_stall", {31'b0, bus.ISSUE_STALL}, 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // 2. issue x5, then write it with bypass read in the same cycle
        bus.ADDR_1 = 5'd5; bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd5;
        tick();
        idle();
        #1 check("x5_busy_pend", {31'b0, bus.BUSY_1}, 32'h1);
        bus.WRITE_EN = 1'b1; bus.WRITE_ADDR = 5'd5; bus.WRITE_DATA = 32'hDEADBEEF;
        bus.DBG_ADDR = 5'd5;
        #1;
        check("x5_bypass", bus.DATA_1, 32'hDEADBEEF);
        check("x5_busy_wb", {31'b0, bus.BUSY_1}, 32'h0);
        check("x5_dbg_nobyp", bus.DBG_DATA, 32'h0);
        tick();
        idle();
        #1;
        check("x5_dbg", bus.DBG_DATA, 32'hDEADBEEF);
        check("x5_err", {31'b0, bus.ERR_UNDER}, 32'h0);

        // 3. x0 is hardwired
        bus.ADDR_1 = 5'd0;
        bus.WRITE_EN = 1'b1; bus.WRITE_ADDR = 5'd0; bus.WRITE_DATA = 32'h1234;
        bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd0;
        #1;
        check("x0_d1", bus.DATA_1, 32'h0);
        check("x0_busy", {31'b0, bus.BUSY_1}, 32'h0);
        check("x0_stall", {31'b0, bus.ISSUE_STALL}, 32'h0);
        tick();
        idle();
        bus.DBG_ADDR = 5'd0;
        #1;
        check("x0_dbg", bus.DBG_DATA, 32'h0);
        check("x0_busy2", {31'b0, bus.BUSY_1}, 32'h0);
        check("x0_err", {31'b0, bus.ERR_UNDER}, 32'h0);

        // 4. saturate x7, stall, stall-with-writeback, drain
        bus.ADDR_1 = 5'd7; bus.ADDR_2 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd7;
            #1 check("x7_nostall", {31'b0, bus.ISSUE_STALL}, 32'h0);
            tick();
            check("x7_busy_up", {31'b0, bus.BUSY_1}, 32'h1);
        end
        #1 check("x7_stall", {31'b0, bus.ISSUE_STALL}, 32'h1);
        tick();
        idle();
        bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd7;
        bus.WRITE_EN = 1'b1; bus.WRITE_ADDR = 5'd7; bus.WRITE_DATA = 32'h7000_0001;
        #1;
        check("x7_stall_wb", {31'b0, bus.ISSUE_STALL}, 32'h1);
        check("x7_busy3", {31'b0, bus.BUSY_2}, 32'h1);
        tick();
        idle();
        bus.WRITE_EN = 1'b1; bus.WRITE_ADDR = 5'd7; bus.WRITE_DATA = 32'h7000_0002;
        #1 check("x7_busy2", {31'b0, bus.BUSY_1}, 32'h1);
        tick();
        bus.WRITE_DATA = 32'h7000_0003;
        #1;
        check("x7_busy_last", {31'b0, bus.BUSY_1}, 32'h0);
        check("x7_byp_last", bus.DATA_2, 32'h7000_0003);
        tick();
        idle();
        bus.DBG_ADDR = 5'd7;
        #1;
        check("x7_busy_idle", {31'b0, bus.BUSY_2}, 32'h0);
        check("x7_dbg", bus.DBG_DATA, 32'h7000_0003);
        check("x7_err", {31'b0, bus.ERR_UNDER}, 32'h0);

        // 5. flush with concurrent issue
        bus.ADDR_1 = 5'd3; bus.ADDR_2 = 5'd4;
        bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd3;
        tick();
        bus.ISSUE_ADDR = 5'd4;
        tick();
        idle();
        #1 check("fl_busy_pre", {30'b0, bus.BUSY_1, bus.BUSY_2}, 32'h3);
        bus.FLUSH = 1'b1; bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd4;
        #1 check("fl_stall", {31'b0, bus.ISSUE_STALL}, 32'h0);
        tick();
        idle();
        bus.DBG_ADDR = 5'd5;
        #1;
        check("fl_busy_post", {30'b0, bus.BUSY_1, bus.BUSY_2}, 32'h1);
        check("fl_data", bus.DBG_DATA, 32'hDEADBEEF);
        bus.WRITE_EN = 1'b1; bus.WRITE_ADDR = 5'd4; bus.WRITE_DATA = 32'h4444;
        tick();
        idle();
        #1;
        check("fl_drain", {30'b0, bus.BUSY_1, bus.BUSY_2}, 32'h0);
        check("fl_err", {31'b0, bus.ERR_UNDER}, 32'h0);

        // 6. underflow write-back, then async reset mid-cycle
        bus.WRITE_EN = 1'b1; bus.WRITE_ADDR = 5'd9; bus.WRITE_DATA = 32'hCAFEF00D;
        tick();
        idle();
        bus.DBG_ADDR = 5'd9; bus.ADDR_1 = 5'd9;
        #1;
        check("uf_data", bus.DBG_DATA, 32'hCAFEF00D);
        check("uf_err", {31'b0, bus.ERR_UNDER}, 32'h1);
        bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd9;
        tick();
        bus.WRITE_EN = 1'b1; bus.WRITE_ADDR = 5'd2; bus.WRITE_DATA = 32'h2222;
        #1 check("uf_busy", {31'b0, bus.BUSY_1}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_d1", bus.DATA_1, 32'h0);
        check("ar_dbg", bus.DBG_DATA, 32'h0);
        check("ar_err", {31'b0, bus.ERR_UNDER}, 32'h0);
        check("ar_busy", {31'b0, bus.BUSY_1}, 32'h0);
        tick();
        bus.DBG_ADDR = 5'd2;
        #1 check("ar_lost_wr", bus.DBG_DATA, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
